// File: rtl/fifo_burst_writer_if.sv
// AXI-style write address/data/response channel bundle for the DMA burst writer.
// The master side issues bursts; the slave side is the memory/interconnect.
interface fifo_burst_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// DMA write engine: drains a 1-cycle-latency FIFO read port into incrementing
// AXI-style bursts of up to MAX_BURST beats, one transfer per start pulse.
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [31:0]           dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  fifo_burst_writer_if.master   bus
);

  localparam int BW    = 9;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_e;

  function automatic logic [BW-1:0] burst_beats(input logic [LEN_WIDTH-1:0] rem);
    if (32'(rem) >= 32'(MAX_BURST)) return BW'(MAX_BURST);
    else                            return BW'(rem);
  endfunction

  state_e                state_q;
  logic [31:0]           addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [BW-1:0]         beats_q;
  logic [BW-1:0]         fetched_q;
  logic [BW-1:0]         sent_q;
  logic [DATA_WIDTH-1:0] data_buf_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  rd_pend_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic                  awvalid_q;
  logic [31:0]           awaddr_q;
  logic [7:0]            awlen_q;
  logic                  bready_q;

  logic                  wvalid;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            occupancy;
  logic [1:0]            count_d;
  logic [LEN_WIDTH-1:0]  rem_next;
  logic [BW-1:0]         first_beats;
  logic [BW-1:0]         next_beats;

  always_comb begin
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    wvalid      = (state_q == S_DATA) && (count_q != 2'd0);
    pop         = wvalid && bus.wready;
    // Buffer slots already committed: held words plus the read landing next edge.
    occupancy   = 3'(count_q) + 3'(rd_pend_q) - 3'(pop);
    rd_en       = ((state_q == S_ADDR) || (state_q == S_DATA)) && !fifo_empty_i &&
                  (fetched_q < beats_q) && (occupancy < 3'd2);
    count_d     = count_q + 2'(rd_pend_q) - 2'(pop);
    rem_next    = remaining_q - LEN_WIDTH'(beats_q);
    first_beats = burst_beats(len_words_i);
    next_beats  = burst_beats(rem_next);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      fetched_q     <= '0;
      sent_q        <= '0;
      // NOTE: this two-entry buffer drives wdata directly, so it is cleared on reset;
      // deeper storage arrays would normally be left unreset.
      data_buf_q[0] <= '0;
      data_buf_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      rd_pend_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      bready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so all registers see pre-edge values
      // and the later FSM assignments cleanly override the datapath defaults below.
      rd_pend_q <= rd_en;
      count_q   <= count_d;
      if (rd_pend_q) begin
        data_buf_q[wr_ptr_q] <= fifo_rdata_i;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        sent_q   <= sent_q + BW'(1);
      end
      if (rd_en) fetched_q <= fetched_q + BW'(1);

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            addr_q      <= dst_addr_i;
            remaining_q <= len_words_i;
            if (len_words_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_ADDR;
              beats_q   <= first_beats;
              awlen_q   <= 8'(first_beats - BW'(1));
              awaddr_q  <= dst_addr_i;
              awvalid_q <= 1'b1;
              fetched_q <= '0;
              sent_q    <= '0;
            end
          end
        end
        S_ADDR: begin
          if (bus.awready) begin
            awvalid_q <= 1'b0;
            addr_q    <= addr_q + 32'(beats_q) * 32'(BYTES);
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (pop && (sent_q == beats_q - BW'(1))) begin
            state_q  <= S_RESP;
            bready_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (bus.bvalid) begin
            bready_q    <= 1'b0;
            remaining_q <= rem_next;
            if (bus.bresp != 2'b00) error_q <= 1'b1;
            if (rem_next == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_ADDR;
              beats_q   <= next_beats;
              awlen_q   <= 8'(next_beats - BW'(1));
              awaddr_q  <= addr_q;
              awvalid_q <= 1'b1;
              fetched_q <= '0;
              sent_q    <= '0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign fifo_rd_en_o = rd_en;

  assign bus.awvalid  = awvalid_q;
  assign bus.awaddr   = awaddr_q;
  assign bus.awlen    = awlen_q;
  assign bus.wvalid   = wvalid;
  assign bus.wdata    = data_buf_q[rd_ptr_q];
  assign bus.wlast    = wvalid && (sent_q == beats_q - BW'(1));
  assign bus.bready   = bready_q;

endmodule
